ann_fp32_argmax: RTL and testbench

//   Output-layer classifier stage of the floating-point ANN.

---
 rtl/ann_fp32_argmax.sv | 135 +++++++++++++
 tb/tb_ann_fp32_argmax.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ann_fp32_argmax.sv
// Argmax classifier over NUM_CLASSES fp32 scores streamed one per beat; reports the winning index.
// Optional macro ARGMAX_NAN_FLAG_EN adds a sticky nan_flag output registered with the label.
module ann_fp32_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4,
    parameter int RET_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_port,
    input  logic             score_valid,
    input  logic [31:0]      score_data,
    output logic             score_ready,
    output logic             done_port,
    output logic [RET_W-1:0] return_port
`ifdef ARGMAX_NAN_FLAG_EN
    ,
    output logic             nan_flag
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] count;
    logic [IDX_W-1:0] best_idx;
    logic [31:0]      best_key;
    logic             accept;
    logic             last_beat;
    logic             take;
    logic             beat_nan;
    logic [31:0]      beat_key;
    logic [IDX_W-1:0] next_best_idx;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Monotonic unsigned key: -0 folds onto +0, NaN sinks below everything.
    function automatic logic [31:0] order_key(input logic [31:0] x);
        logic [31:0] c;
        c = (x == 32'h8000_0000) ? 32'd0 : x;
        if (is_nan(c))
            return 32'd0;
        return c[31] ? ~c : (c ^ 32'h8000_0000);
    endfunction

    assign beat_nan      = is_nan(score_data);
    assign beat_key      = order_key(score_data);
    assign take          = (count == '0) || (beat_key > best_key);
    assign next_best_idx = take ? count : best_idx;
    assign last_beat     = (count == LAST_IDX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        score_ready = 1'b0;
        done_port   = 1'b0;
        accept      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_port)
                    state_next = COLLECT;
            end
            COLLECT: begin
                score_ready = 1'b1;
                accept      = score_valid;
                if (score_valid && last_beat)
                    state_next = DONE;
            end
            DONE: begin
                done_port  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The label register loads on the last accepted beat, so it is visible exactly in DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            best_idx    <= '0;
            best_key    <= '0;
            return_port <= '0;
        end else if (state == IDLE && start_port) begin
            count    <= '0;
            best_idx <= '0;
            best_key <= '0;
        end else if (accept) begin
            count <= count + IDX_W'(1);
            if (take) begin
                best_idx <= count;
                best_key <= beat_key;
            end
            if (last_beat)
                return_port <= RET_W'(next_best_idx);
        end
    end

`ifdef ARGMAX_NAN_FLAG_EN
    logic nan_seen;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            nan_seen <= 1'b0;
            nan_flag <= 1'b0;
        end else if (state == IDLE && start_port) begin
            nan_seen <= 1'b0;
        end else if (accept) begin
            nan_seen <= nan_seen | beat_nan;
            if (last_beat)
                nan_flag <= nan_seen | beat_nan;
        end
    end
`else
    // Without the flag, NaN beats only influence ordering through order_key.
    logic unused_nan;
    assign unused_nan = beat_nan;
`endif

endmodule

// File: tb/tb_ann_fp32_argmax.sv
// Directed self-checking bench for ann_fp32_argmax (covers nan_flag when ARGMAX_NAN_FLAG_EN is defined).
module tb_ann_fp32_argmax;

    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;
    localparam int RET_W       = 32;

    logic             clock;
    logic             reset;
    logic             start_port;
    logic             score_valid;
    logic [31:0]      score_data;
    logic             score_ready;
    logic             done_port;
    logic [RET_W-1:0] return_port;
`ifdef ARGMAX_NAN_FLAG_EN
    logic             nan_flag;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [31:0] frame [NUM_CLASSES];

    ann_fp32_argmax #(
        .NUM_CLASSES(NUM_CLASSES),
        .IDX_W      (IDX_W),
        .RET_W      (RET_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start_port (start_port),
        .score_valid(score_valid),
        .score_data (score_data),
        .score_ready(score_ready),
        .done_port  (done_port),
        .return_port(return_port)
`ifdef ARGMAX_NAN_FLAG_EN
        ,
        .nan_flag   (nan_flag)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (done_port) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < NUM_CLASSES; i++) frame[i] = v;
    endtask

    task automatic run_frame(input string tag, input bit stall, input bit hold_start,
                             input logic [31:0] prev_label, input logic [31:0] exp_label,
                             input bit exp_nan);
        int base;
        int c0;
        base = done_cnt;
        start_port = 1'b1;
        tick;
        c0 = cyc;
        start_port = hold_start;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (stall) begin
                score_valid = 1'b0;
                repeat ($urandom_range(1, 2)) tick;
            end
            score_valid = 1'b1;
            score_data  = frame[k];
            tick;
            if (k == 4) begin
                check({tag, "_hold_ret"}, return_port, prev_label);
                check({tag, "_ready"}, {31'd0, score_ready}, 32'd1);
            end
        end
        score_valid = 1'b0;
        check({tag, "_done"}, {31'd0, done_port}, 32'd1);
        check({tag, "_label"}, return_port, exp_label);
        if (!stall) check({tag, "_latency"}, cyc - c0, NUM_CLASSES);
`ifdef ARGMAX_NAN_FLAG_EN
        check({tag, "_nan"}, {31'd0, nan_flag}, {31'd0, exp_nan});
`else
        if (exp_nan) checks = checks + 0;
`endif
        start_port = 1'b0;
        tick;
        check({tag, "_done_low"}, {31'd0, done_port}, 32'd0);
        check({tag, "_pulses"}, done_cnt - base, 32'd1);
        check({tag, "_label_held"}, return_port, exp_label);
    endtask

    initial begin
        int base;
        reset       = 1'b0;
        start_port  = 1'b0;
        score_valid = 1'b0;
        score_data  = 32'd0;
        #1;
        check("rst_ready", {31'd0, score_ready}, 32'd0);
        check("rst_done", {31'd0, done_port}, 32'd0);
        check("rst_ret", return_port, 32'd0);
`ifdef ARGMAX_NAN_FLAG_EN
        check("rst_nan", {31'd0, nan_flag}, 32'd0);
`endif
        tick;
        tick;
        reset = 1'b1;
        tick;
        check("idle_ready", {31'd0, score_ready}, 32'd0);

        // Mixed values: 3.25 at class 3 is the maximum.
        frame[0] = 32'h3DCC_CCCD; frame[1] = 32'h3F00_0000; frame[2] = 32'hC000_0000;
        frame[3] = 32'h4050_0000; frame[4] = 32'h0;         frame[5] = 32'h0;
        frame[6] = 32'h0;         frame[7] = 32'h0;         frame[8] = 32'h0;
        frame[9] = 32'h3F80_0000;
        run_frame("t1", 1'b0, 1'b0, 32'd0, 32'd3, 1'b0);

        fill(32'h3F80_0000);
        run_frame("t2_tie", 1'b0, 1'b0, 32'd3, 32'd0, 1'b0);

        fill(32'hBF80_0000);
        frame[4] = 32'h8000_0000;
        frame[7] = 32'h0000_0000;
        run_frame("t3_zero", 1'b0, 1'b0, 32'd0, 32'd4, 1'b0);

        fill(32'hC000_0000);
        frame[2] = 32'h7FC0_0000;
        frame[5] = 32'hFF80_0000;
        run_frame("t4_nan", 1'b0, 1'b0, 32'd4, 32'd0, 1'b1);

        frame[0] = 32'h3DCC_CCCD; frame[1] = 32'h3F00_0000; frame[2] = 32'hC000_0000;
        frame[3] = 32'h4050_0000; frame[4] = 32'h0;         frame[5] = 32'h0;
        frame[6] = 32'h0;         frame[7] = 32'h0;         frame[8] = 32'h0;
        frame[9] = 32'h3F80_0000;
        run_frame("t5_stall", 1'b1, 1'b1, 32'd0, 32'd3, 1'b0);

        fill(32'hC000_0000);
        frame[1] = 32'hFF80_0000;
        frame[6] = 32'h7F80_0000;
        frame[8] = 32'h7F7F_FFFF;
        run_frame("inf", 1'b0, 1'b0, 32'd3, 32'd6, 1'b0);

        fill(32'h7FC0_0000);
        frame[3] = 32'hFFC0_0001;
        run_frame("allnan", 1'b0, 1'b0, 32'd6, 32'd0, 1'b1);

        // Reset after 5 accepted beats: frame is discarded with no done pulse.
        base = done_cnt;
        start_port = 1'b1;
        tick;
        start_port = 1'b0;
        for (int k = 0; k < 5; k++) begin
            score_valid = 1'b1;
            score_data  = 32'h4100_0000;
            tick;
        end
        score_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("t6_rst_ready", {31'd0, score_ready}, 32'd0);
        check("t6_rst_done", {31'd0, done_port}, 32'd0);
        check("t6_rst_ret", return_port, 32'd0);
        tick;
        tick;
        reset = 1'b1;
        repeat (3) tick;
        check("t6_no_stale_done", done_cnt - base, 32'd0);
        check("t6_idle_ready", {31'd0, score_ready}, 32'd0);

        fill(32'h3F80_0000);
        frame[9] = 32'h4000_0000;
        run_frame("t6_last", 1'b0, 1'b0, 32'd0, 32'd9, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
